// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory port arbiter, its two requesters and the memory.
// The arbiter takes the slave view; the requesters/memory side takes the master view.
interface mem_port_arbiter_if #(
  parameter int N = 32,
  parameter int M = 16
);
  logic         if_req;
  logic [M-1:0] if_addr;
  logic         if_gnt;
  logic         if_valid;
  logic         d_req;
  logic         d_we;
  logic [M-1:0] d_addr;
  logic [N-1:0] d_wdata;
  logic [N-1:0] d_mask;
  logic         d_gnt;
  logic         d_valid;
  logic [N-1:0] rdata;
  logic         mem_en;
  logic         mem_we;
  logic [M-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_mask;
  logic [N-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_mask, mem_rdata,
    output if_gnt, if_valid, d_gnt, d_valid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_mask
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_mask, mem_rdata,
    input  if_gnt, if_valid, d_gnt, d_valid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_mask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data
// access; one access in flight, fixed read latency, registered outputs.
module mem_port_arbiter #(
  parameter int N   = 32,
  parameter int M   = 16,
  parameter int LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  halted,
  mem_port_arbiter_if.slave     bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [3:0] LAT_C   = 4'(LAT);

  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         last_q, last_d;   // 1 = data side won last
  logic         win_q, win_d;     // 1 = data side owns the current access
  logic         if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic         if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic         mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [M-1:0] mem_addr_q, mem_addr_d;
  logic [N-1:0] mem_wdata_q, mem_wdata_d;
  logic [N-1:0] mem_mask_q, mem_mask_d;
  logic         pick_d;

  // Data wins when it is the only requester, or on a tie when fetch went last.
  assign pick_d = bus.d_req & (~bus.if_req | ~last_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    win_d       = win_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    case (state_q)
      S_IDLE: begin
        if ((bus.if_req | bus.d_req) && !halted) begin
          state_d  = S_ISSUE;
          win_d    = pick_d;
          last_d   = pick_d;
          mem_en_d = 1'b1;
          if (pick_d) begin
            d_gnt_d     = 1'b1;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            mem_mask_d  = bus.d_we ? bus.d_mask : '0;
          end else begin
            if_gnt_d   = 1'b1;
            mem_addr_d = bus.if_addr;
            mem_mask_d = '0;
          end
        end
      end
      S_ISSUE: begin
        // mem_we_q is high only while a write is being issued.
        if (mem_we_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = 4'd1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT_C) begin
          rdata_d    = bus.mem_rdata;
          state_d    = S_DONE;
          d_valid_d  = win_q;
          if_valid_d = ~win_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      win_q       <= win_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_mask  = mem_mask_q;

endmodule
